// File: rtl/shift_reg_univ_sync_n_if.sv
// Bus bundle for the universal shift register: control and data toward the
// register (master), register state back to the user (slave).
interface shift_reg_univ_sync_n_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             clr;
    logic             set;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CW-1:0]    cnt;
    logic             empty;

    modport master (
        output clr, set, en, mode, d, sin_l, sin_r,
        input  q, sout, cnt, empty
    );

    modport slave (
        input  clr, set, en, mode, d, sin_l, sin_r,
        output q, sout, cnt, empty
    );
endinterface

// File: rtl/shift_reg_univ_sync_n.sv
// Loadable, shiftable WIDTH-bit register with optional rotate and a saturating
// count of shifts since the last load/clear/set/reset.
module shift_reg_univ_sync_n #(
    parameter int WIDTH  = 8,
    parameter int ROTATE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_reg_univ_sync_n_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [WIDTH-1:0] q_reg;
    logic             sout_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;
    logic             in_l;
    logic             in_r;
    logic [CW-1:0]    cnt_next;

    // In rotate mode the outgoing bit re-enters at the opposite end.
    assign in_l = (ROTATE != 0) ? q_reg[WIDTH-1] : bus.sin_l;
    assign in_r = (ROTATE != 0) ? q_reg[0]       : bus.sin_r;

    assign shl_next[0]       = in_l;
    assign shr_next[WIDTH-1] = in_r;

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shl_next[gi]   = q_reg[gi-1];
            assign shr_next[gi-1] = q_reg[gi];
        end
    endgenerate

    assign cnt_next = (cnt_reg == CNT_FULL) ? CNT_FULL : cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg    <= '0;
            sout_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (bus.clr) begin
            q_reg   <= '0;
            cnt_reg <= '0;
        end else if (bus.set) begin
            q_reg   <= '1;
            cnt_reg <= '0;
        end else if (bus.en) begin
            case (bus.mode)
                2'b01: begin
                    q_reg    <= shl_next;
                    sout_reg <= q_reg[WIDTH-1];
                    cnt_reg  <= cnt_next;
                end
                2'b10: begin
                    q_reg    <= shr_next;
                    sout_reg <= q_reg[0];
                    cnt_reg  <= cnt_next;
                end
                2'b11: begin
                    q_reg   <= bus.d;
                    cnt_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.q     = q_reg;
    assign bus.sout  = sout_reg;
    assign bus.cnt   = cnt_reg;
    assign bus.empty = (cnt_reg == CNT_FULL);
endmodule

// File: tb/tb_shift_reg_univ_sync_n.sv
// Directed-vector bench: a ROTATE=0 table plus a hand sequence on a ROTATE=1
// instance, both WIDTH=8.
module tb_shift_reg_univ_sync_n;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    shift_reg_univ_sync_n_if #(.WIDTH(WIDTH)) bus0 ();
    shift_reg_univ_sync_n_if #(.WIDTH(WIDTH)) bus1 ();

    shift_reg_univ_sync_n #(.WIDTH(WIDTH), .ROTATE(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    shift_reg_univ_sync_n #(.WIDTH(WIDTH), .ROTATE(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    typedef struct {
        logic       rst, clr, set, en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin_l, sin_r;
        logic [7:0] q;
        logic       sout;
        logic [3:0] cnt;
        logic       empty;
    } vec_t;

    vec_t vecs[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic add(input logic r, c, s, e, input logic [1:0] m, input logic [7:0] dd,
                       input logic sl, sr, input logic [7:0] eq, input logic es,
                       input logic [3:0] ec, input logic ee);
        vec_t v;
        v.rst = r; v.clr = c; v.set = s; v.en = e; v.mode = m; v.d = dd;
        v.sin_l = sl; v.sin_r = sr; v.q = eq; v.sout = es; v.cnt = ec; v.empty = ee;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string tag, input int idx, input logic [7:0] q, input logic sout,
                       input logic [3:0] cnt, input logic empty, input vec_t v);
        n_vec++;
        if (q !== v.q || sout !== v.sout || cnt !== v.cnt || empty !== v.empty) begin
            n_bad++;
            $display("FAIL %s[%0d] got q=%02h sout=%b cnt=%0d empty=%b want q=%02h sout=%b cnt=%0d empty=%b",
                     tag, idx, q, sout, cnt, empty, v.q, v.sout, v.cnt, v.empty);
        end else begin
            $display("ok   %s[%0d] q=%02h sout=%b cnt=%0d empty=%b", tag, idx, q, sout, cnt, empty);
        end
    endtask

    task automatic rot_step(input int idx, input logic [1:0] m, input logic [7:0] dd,
                            input logic sl, sr, input logic [7:0] eq, input logic es,
                            input logic [3:0] ec, input logic ee);
        vec_t v;
        v.rst = 0; v.clr = 0; v.set = 0; v.en = 1; v.mode = m; v.d = dd;
        v.sin_l = sl; v.sin_r = sr; v.q = eq; v.sout = es; v.cnt = ec; v.empty = ee;
        @(negedge clk);
        rst1 = 1'b0; bus1.clr = 0; bus1.set = 0; bus1.en = 1; bus1.mode = m;
        bus1.d = dd; bus1.sin_l = sl; bus1.sin_r = sr;
        @(posedge clk); #1;
        cmp("rot", idx, bus1.q, bus1.sout, bus1.cnt, bus1.empty, v);
    endtask

    initial begin
        //   rst clr set en mode d     sl sr   q      so cnt e
        add(1, 0, 0, 0, 2'b00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 1, 2'b11, 8'hA5, 0, 0, 8'hA5, 0, 0, 0);
        add(1, 0, 0, 0, 2'b00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 1, 2'b11, 8'hA5, 0, 0, 8'hA5, 0, 0, 0);
        add(1, 1, 1, 1, 2'b11, 8'hFF, 1, 1, 8'h00, 0, 0, 0);
        // load 0xB4 and drain it out of the top
        add(0, 0, 0, 1, 2'b11, 8'hB4, 0, 0, 8'hB4, 0, 0, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h68, 1, 1, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'hD0, 0, 2, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'hA0, 1, 3, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h40, 1, 4, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h80, 0, 5, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h00, 1, 6, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 7, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 8, 1);
        add(0, 0, 0, 1, 2'b01, 8'h00, 0, 0, 8'h00, 0, 8, 1);
        // serial fill from the top
        add(0, 0, 0, 1, 2'b11, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 1, 2'b10, 8'h00, 0, 1, 8'h80, 0, 1, 0);
        add(0, 0, 0, 1, 2'b10, 8'h00, 0, 1, 8'hC0, 0, 2, 0);
        add(0, 0, 0, 1, 2'b10, 8'h00, 0, 1, 8'hE0, 0, 3, 0);
        add(0, 0, 0, 1, 2'b10, 8'h00, 0, 1, 8'hF0, 0, 4, 0);
        // priority: clr beats set and shift; sout left alone
        add(0, 0, 0, 1, 2'b11, 8'hB5, 0, 0, 8'hB5, 0, 0, 0);
        add(0, 0, 0, 1, 2'b10, 8'h00, 0, 0, 8'h5A, 1, 1, 0);
        add(0, 1, 1, 1, 2'b01, 8'h00, 1, 1, 8'h00, 1, 0, 0);
        add(0, 0, 1, 0, 2'b00, 8'h00, 0, 0, 8'hFF, 1, 0, 0);
        // hold with en=0 and with mode=00
        add(0, 0, 0, 1, 2'b11, 8'h78, 0, 0, 8'h78, 1, 0, 0);
        add(0, 0, 0, 1, 2'b10, 8'h00, 0, 0, 8'h3C, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 8'hFF, 1, 1, 8'h3C, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 8'hFF, 1, 1, 8'h3C, 0, 1, 0);
        add(0, 0, 0, 0, 2'b11, 8'hFF, 1, 1, 8'h3C, 0, 1, 0);
        add(0, 0, 0, 1, 2'b00, 8'hFF, 1, 1, 8'h3C, 0, 1, 0);
        add(0, 0, 0, 1, 2'b00, 8'hFF, 1, 1, 8'h3C, 0, 1, 0);
        // direction change: cnt accumulates both directions
        add(0, 0, 0, 1, 2'b01, 8'h00, 1, 0, 8'h79, 0, 2, 0);
        add(0, 0, 0, 1, 2'b10, 8'h00, 0, 1, 8'hBC, 1, 3, 0);
        // reset mid-shift, then normal operation resumes
        add(1, 0, 0, 1, 2'b01, 8'h00, 1, 1, 8'h00, 0, 0, 0);
        add(0, 0, 0, 1, 2'b01, 8'h00, 1, 1, 8'h01, 0, 1, 0);

        bus0.clr = 0; bus0.set = 0; bus0.en = 0; bus0.mode = 0;
        bus0.d = 0; bus0.sin_l = 0; bus0.sin_r = 0;
        bus1.clr = 0; bus1.set = 0; bus1.en = 0; bus1.mode = 0;
        bus1.d = 0; bus1.sin_l = 0; bus1.sin_r = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst0 = vecs[i].rst; bus0.clr = vecs[i].clr; bus0.set = vecs[i].set;
            bus0.en = vecs[i].en; bus0.mode = vecs[i].mode; bus0.d = vecs[i].d;
            bus0.sin_l = vecs[i].sin_l; bus0.sin_r = vecs[i].sin_r;
            @(posedge clk); #1;
            cmp("tbl", i, bus0.q, bus0.sout, bus0.cnt, bus0.empty, vecs[i]);
        end

        // rotate instance: serial inputs toggle but must not matter
        rot_step(0,  2'b11, 8'h81, 1, 1, 8'h81, 0, 0, 0);
        rot_step(1,  2'b01, 8'h00, 0, 1, 8'h03, 1, 1, 0);
        rot_step(2,  2'b10, 8'h00, 1, 0, 8'h81, 1, 2, 0);
        rot_step(3,  2'b10, 8'h00, 0, 1, 8'hC0, 1, 3, 0);
        rot_step(4,  2'b10, 8'h00, 1, 1, 8'h60, 0, 4, 0);
        rot_step(5,  2'b10, 8'h00, 0, 0, 8'h30, 0, 5, 0);
        rot_step(6,  2'b10, 8'h00, 1, 0, 8'h18, 0, 6, 0);
        rot_step(7,  2'b10, 8'h00, 0, 1, 8'h0C, 0, 7, 0);
        rot_step(8,  2'b10, 8'h00, 1, 1, 8'h06, 0, 8, 1);
        rot_step(9,  2'b10, 8'h00, 0, 0, 8'h03, 0, 8, 1);
        rot_step(10, 2'b10, 8'h00, 1, 0, 8'h81, 1, 8, 1);
        rot_step(11, 2'b01, 8'h00, 0, 1, 8'h03, 1, 8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_reg_univ_sync_n.md
# shift_reg_univ_sync_n

Parametrised universal register: a WIDTH-bit storage element with synchronous reset, clear and set, plus parallel load, shift-left, shift-right and optional rotate. It also keeps a saturating count of shifts since the last load, clear or set. It is the generalised successor of the team's single-bit D flip-flop cells. It is used wherever datapath or serial-interface logic needs a loadable, shiftable register with a known fill/drain state.

## Interface
- WIDTH, 8, register width in bits; legal range WIDTH ≥ 2.
- ROTATE, 0, 0 = shifts take serial inputs; 1 = the outgoing bit re-enters at the opposite end and the serial inputs are ignored.
- CW, $clog2(WIDTH+1), width of the shift counter; derived, do not override.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear, active-high.
- set  in  1  synchronous set to all ones, active-high.
- en  in  1  operation enable for mode.
- mode  in  2  00 hold, 01 shift-left, 10 shift-right, 11 parallel load.
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input for shift-left; enters bit 0.
- sin_r  in  1  serial input for shift-right; enters bit WIDTH-1.
- q  out  WIDTH  register contents.
- sout  out  1  registered copy of the last bit shifted out.
- cnt  out  CW  shifts since last load/clr/set/rst; saturates at WIDTH.
- empty  out  1  combinational, high when cnt == WIDTH (every loaded bit has left the register).

Reset is synchronous, active-high on rst, sampled on the rising edge of clk; one clock domain only.

## Operation
- Priority per rising clk edge: rst > clr > set > (en && mode) > hold.
- **rst:** q=0, sout=0, cnt=0, so empty=0.
- **clr:** q=0, cnt=0; sout unchanged.
- **set:** q=all ones, cnt=0; sout unchanged. clr and set high together behave as clr.
- **load (en, mode=11):** q=d, cnt=0; sout unchanged.
- **shift-left (en, mode=01):**
  - q = {q[WIDTH-2:0], in}, where in = sin_l, or q[WIDTH-1] when ROTATE=1.
  - sout = old q[WIDTH-1].
  - cnt = min(cnt+1, WIDTH).
- **shift-right (en, mode=10):**
  - q = {in, q[WIDTH-1:1]}, where in = sin_r, or q[0] when ROTATE=1.
  - sout = old q[0].
  - cnt = min(cnt+1, WIDTH).
- **hold:** mode=00 or en=0 → all state unchanged.
- Shifting continues after empty is asserted. q keeps updating and sout tracks the outgoing bit; cnt stays at WIDTH.
- Direction may change between consecutive cycles. cnt counts shifts in either direction and does not net them.
- The ROTATE=1 counter and empty behave identically to ROTATE=0.

## Timing
- Every operation has single-cycle latency: inputs sampled at edge N appear on q/sout/cnt after edge N.
- empty follows cnt in the same cycle, with no extra register.
- Reset mid-shift overrides any in-flight operation at that edge; the next edge resumes normal operation.
- No handshake: an operation is issued every cycle that en=1 and mode≠00.
- Out-of-range CW values cannot occur; the counter never increments past WIDTH.
- All outputs are glitch-free register outputs except empty.

## Test plan
- **Reset:** drive rst=1 with q previously 0xA5 → after the edge q=0x00, sout=0, cnt=0, empty=0. Repeat with clr=set=1 and en=1, mode=11; rst still wins.
- **Load then shift-left drain (WIDTH=8, ROTATE=0):** load 0xB4, then 8 shift-left cycles with sin_l=0.
  - sout sequence: 1,0,1,1,0,1,0,0.
  - q=0x00, cnt=8, empty=1.
  - A 9th shift keeps cnt=8.
- **Shift-right with serial fill:** load 0x00, then 4 shift-right cycles with sin_r=1 → q=0xF0, sout=0, cnt=4, empty=0.
- **Rotate (ROTATE=1):** load 0x81, shift-left once → q=0x03, sout=1. Shift-right twice → q=0xC0, cnt=3. sin_l/sin_r toggling has no effect.
- **Priority/simultaneous:**
  - clr=1, set=1, en=1, mode=01 from q=0x5A → q=0x00, cnt=0.
  - set=1 alone → q=0xFF, cnt=0, sout unchanged.
- **Hold/enable:** q=0x3C, en=0 with mode=01 for 3 cycles → q, cnt and sout unchanged. en=1, mode=00 gives the same result.
